// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        FIN
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ID      = 2'b01;
    localparam logic [1:0] ERR_TS      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_check_timer.sv
// Stall counter: counts enabled cycles, flags the cycle that would be the LIMIT-th stall.
module sysid_check_timer #(
    parameter int LIMIT = 255,
    localparam int W    = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    // Asserted during the stall cycle whose edge completes LIMIT stalls.
    assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and checks them.
module sysid_boot_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1643044096,
    parameter bit          AUTO_START     = 1'b1,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] id_q,
    output logic [31:0] ts_q
);

    state_t state, state_nx;
    logic   auto_pend;
    logic   req;
    logic   accept;
    logic   stall;
    logic   expired;

    // Strobe and address decode straight from state, so reset drops them asynchronously.
    assign avm_read    = (state == RD_ID) || (state == RD_TS);
    assign avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
    assign accept      = avm_read && !avm_waitrequest;
    assign stall       = avm_read && avm_waitrequest;
    assign req         = start || auto_pend;

    sysid_check_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!avm_read || accept),
        .enable  (stall),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FIN: if (req) state_nx = RD_ID;
            RD_ID: begin
                if (accept)       state_nx = RD_TS;
                else if (expired) state_nx = FIN;
            end
            RD_TS: begin
                if (accept)       state_nx = CHECK;
                else if (expired) state_nx = FIN;
            end
            CHECK:   state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= AUTO_START;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_code  <= ERR_OK;
            id_q      <= '0;
            ts_q      <= '0;
        end else begin
            auto_pend <= 1'b0;
            if ((state == IDLE || state == FIN) && req) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                pass     <= 1'b0;
                err_code <= ERR_OK;
            end
            if (state == RD_ID && accept) id_q <= avm_readdata;
            if (state == RD_TS && accept) ts_q <= avm_readdata;
            if (expired) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                pass     <= 1'b0;
                err_code <= ERR_TIMEOUT;
            end
            if (state == CHECK) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (id_q != EXPECTED_ID)
                    err_code <= ERR_ID;
                else if (ts_q != EXPECTED_TS)
                    err_code <= ERR_TS;
                else begin
                    err_code <= ERR_OK;
                    pass     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomised self-checking bench: two checkers (auto-start and manual) against a slave model.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1643044096;
    localparam int          TMO    = 8;

    logic             clk = 1'b0;
    logic [1:0]       rst_n, start, avm_read, avm_address, wr, busy, done, pass;
    logic [1:0][1:0]  err;
    logic [1:0][31:0] rdata, id_q, ts_q;

    int          need [2][2];
    logic [31:0] sdata[2][2];
    int          scnt [2] = '{0, 0};
    int          nacc [2] = '{0, 0};
    logic [1:0]  clr_acc = '0;
    logic [1:0]  prev_stall = '0, prev_addr = '0, stab_bad = '0;
    logic [31:0] junk = '0;
    logic [31:0] eid[2], ets[2];
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sysid_boot_checker #(
            .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
            .AUTO_START(g == 0), .TIMEOUT_CYCLES(TMO)
        ) u_dut (
            .clock(clk), .reset_n(rst_n[g]), .start(start[g]),
            .avm_address(avm_address[g]), .avm_read(avm_read[g]),
            .avm_readdata(rdata[g]), .avm_waitrequest(wr[g]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]), .err_code(err[g]),
            .id_q(id_q[g]), .ts_q(ts_q[g])
        );
    end

    // Slave: stall need[i][addr] cycles per read, then accept; garbage data while stalled.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr[i]    = avm_read[i] && (scnt[i] < need[i][avm_address[i]]);
            rdata[i] = (avm_read[i] && !wr[i]) ? sdata[i][avm_address[i]] : junk;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr_acc[i]) nacc[i] <= 0;
            else if (avm_read[i] && !wr[i]) nacc[i] <= nacc[i] + 1;
            if (!avm_read[i] || !wr[i]) scnt[i] <= 0;
            else scnt[i] <= scnt[i] + 1;
        end
    end

    always @(negedge clk) begin
        junk <= $urandom;
        for (int i = 0; i < 2; i++) begin
            if (prev_stall[i] && avm_read[i] && avm_address[i] != prev_addr[i])
                stab_bad[i] <= 1'b1;
            prev_stall[i] <= avm_read[i] && wr[i];
            prev_addr[i]  <= avm_address[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One check; via_rst starts it through the auto-start one-shot, extra adds stray starts.
    task automatic txn(input int i, input bit via_rst, input bit extra, input int s0,
                       input int s1, input logic [31:0] idw, input logic [31:0] tsw);
        int lat, exp_lat, exp_acc;
        logic [1:0] exp_err;
        bit got;
        @(negedge clk);
        need[i][0] = s0; need[i][1] = s1;
        sdata[i][0] = idw; sdata[i][1] = tsw;
        clr_acc[i] = 1'b1;
        @(negedge clk);
        clr_acc[i] = 1'b0;
        if (via_rst) begin
            eid[i] = '0; ets[i] = '0;
        end
        if (s0 >= TMO) begin
            exp_lat = 1 + TMO; exp_err = 2'b11; exp_acc = 0;
        end else if (s1 >= TMO) begin
            exp_lat = 2 + s0 + TMO; exp_err = 2'b11; exp_acc = 1; eid[i] = idw;
        end else begin
            exp_lat = 4 + s0 + s1; exp_acc = 2; eid[i] = idw; ets[i] = tsw;
            exp_err = (idw != EXP_ID) ? 2'b01 : (tsw != EXP_TS) ? 2'b10 : 2'b00;
        end
        if (via_rst) begin
            rst_n[i] = 1'b0;
            #1 rst_n[i] = 1'b1;
            start[i] = extra;
        end else begin
            start[i] = 1'b1;
        end
        lat = 0; got = 0;
        while (!got && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done[i]) begin
                got = 1; start[i] = 1'b0;
            end else begin
                start[i] = extra ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        start[i] = 1'b0;
        chk("done", 32'(got), 1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err_code", 32'(err[i]), 32'(exp_err));
        chk("pass", 32'(pass[i]), 32'(exp_err == 2'b00));
        chk("busy_fin", 32'(busy[i]), 0);
        chk("read_fin", 32'(avm_read[i]), 0);
        chk("id_q", id_q[i], eid[i]);
        chk("ts_q", ts_q[i], ets[i]);
        chk("accepts", 32'(nacc[i]), 32'(exp_acc));
        chk("addr_stable", 32'(stab_bad[i]), 0);
    endtask

    function automatic int pick_stall();
        int r = $urandom_range(0, 9);
        return (r < 6) ? r % 4 : (r < 8) ? TMO - 1 : TMO + $urandom_range(0, 3);
    endfunction

    initial begin
        rst_n = '0; start = '0;
        for (int i = 0; i < 2; i++) begin
            need[i][0] = 0; need[i][1] = 0;
            sdata[i][0] = EXP_ID; sdata[i][1] = EXP_TS;
            eid[i] = '0; ets[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
            chk("rst_pass", 32'(pass[i]), 0);
            chk("rst_err", 32'(err[i]), 0);
            chk("rst_read", 32'(avm_read[i]), 0);
            chk("rst_addr", 32'(avm_address[i]), 0);
            chk("rst_id", id_q[i], 0);
            chk("rst_ts", ts_q[i], 0);
        end

        txn(0, 1, 0, 0, 0, EXP_ID, EXP_TS);       // auto-start after reset
        txn(0, 0, 0, 0, 0, 32'h5, EXP_TS);        // ID mismatch
        txn(0, 0, 0, 0, 0, EXP_ID, EXP_TS + 1);   // TS mismatch
        txn(0, 0, 0, 3, 3, EXP_ID, EXP_TS);       // 3-cycle stalls
        txn(0, 0, 0, 100, 0, EXP_ID, EXP_TS);     // timeout on ID
        txn(0, 0, 0, 0, 100, EXP_ID, EXP_TS);     // timeout on TS
        txn(0, 0, 0, TMO - 1, TMO - 1, EXP_ID, EXP_TS);
        txn(0, 1, 1, 0, 1, EXP_ID, EXP_TS);       // start coincident with one-shot

        // Manual instance: reset while RD_TS stalls, nothing must survive.
        rst_n[1] = 1'b1;
        @(negedge clk);
        need[1][0] = 0; need[1][1] = 20; sdata[1][0] = 32'h1234;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rd_ts", 32'(avm_read[1] && avm_address[1]), 1);
        rst_n[1] = 1'b0;
        #1;
        chk("mid_rst_read", 32'(avm_read[1]), 0);
        chk("mid_rst_busy", 32'(busy[1]), 0);
        chk("mid_rst_id", id_q[1], 0);
        #1 rst_n[1] = 1'b1;
        eid[1] = '0; ets[1] = '0;
        repeat (3) @(negedge clk);
        chk("idle_read", 32'(avm_read[1]), 0);
        chk("idle_busy", 32'(busy[1]), 0);
        chk("idle_done", 32'(done[1]), 0);
        txn(1, 0, 1, 0, 2, EXP_ID, EXP_TS);

        repeat (40) begin
            int i, s0, s1;
            logic [31:0] idw, tsw;
            i   = $urandom_range(0, 1);
            s0  = pick_stall();
            s1  = pick_stall();
            idw = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
            tsw = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
            txn(i, (i == 0) && ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                s0, s1, idw, tsw);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
Avalon-MM read master that sits directly downstream of the system-ID slave. It consumes the slave's readdata at boot or on request: it reads the ID word at address 0 and the timestamp word at address 1. It compares both words against build-time expected values and reports pass/fail plus the captured words to the boot controller and a status LED/CSR.

Parameters:
EXPECTED_ID, 32'd0, expected system ID word (address 0)
EXPECTED_TS, 32'd1643044096, expected build timestamp word (address 1)
AUTO_START, 1, 1 = start one check automatically after reset deassertion
TIMEOUT_CYCLES, 255, maximum cycles a read may stall on waitrequest (1..65535)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that requests a check
avm_address  out  1  slave word address (0 = ID, 1 = timestamp)
avm_read  out  1  read strobe, held until accepted
avm_readdata  in  32  slave read data, valid when avm_read=1 and avm_waitrequest=0
avm_waitrequest  in  1  slave stall
busy  out  1  check in progress
done  out  1  result valid; sticky until next start
pass  out  1  both words matched (valid only when done=1)
err_code  out  2  00 ok, 01 ID mismatch, 10 TS mismatch (ID ok), 11 timeout
id_q  out  32  captured ID word
ts_q  out  32  captured timestamp word

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on reset_n; all flops clear on assertion.
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, err_code=00, id_q=0, ts_q=0, state=IDLE, timer=0.
- States: IDLE, RD_ID, RD_TS, CHECK, FIN.
- IDLE: a start pulse moves the FSM to RD_ID on the next edge.
  - With AUTO_START=1, an internal one-shot acts as start in the first cycle after reset_n deasserts (fires once per reset).
- Entering RD_ID clears done, pass and err_code and sets busy=1.
- RD_ID: avm_read=1, avm_address=0.
  - On a cycle with avm_waitrequest=0: capture id_q <= avm_readdata, go to RD_TS, reset timer.
- RD_TS: avm_read=1, avm_address=1.
  - On accept: capture ts_q, go to CHECK.
- Avalon rules:
  - avm_address and avm_read stay stable while waitrequest=1.
  - Exactly one accepted read per word.
  - No back-to-back read with changed address inside the same cycle.
- Timeout: a timer counts the cycles avm_read=1 with waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES, drop avm_read and go to FIN with err_code=11, pass=0.
  - A stall of exactly TIMEOUT_CYCLES-1 followed by an accept is not a timeout.
- CHECK (one cycle):
  - ID mismatch gives err 01.
  - Otherwise TS mismatch gives err 10.
  - Otherwise err 00 and pass=1.
  - Go to FIN.
- FIN: done=1, busy=0; outputs hold. start returns the FSM to RD_ID.
- Latency: with waitrequest=0 throughout, start sampled at edge 0 gives RD_ID at cycle 1, RD_TS at cycle 2, CHECK at cycle 3, and done=1 from cycle 4.
- Boundaries:
  - start while busy is ignored.
  - start coincident with the AUTO_START one-shot counts as a single request.
  - reset_n asserted mid-read drops avm_read asynchronously; no partial result is retained.
  - avm_readdata is ignored when not accepted.

Decomposition:
- Package sysid_checker_pkg holds:
  - state enum (IDLE, RD_ID, RD_TS, CHECK, FIN);
  - err_code constants ERR_OK, ERR_ID, ERR_TS, ERR_TIMEOUT;
  - address constants ADDR_ID=0, ADDR_TS=1.
- One sub-module, sysid_check_timer: a stall counter with clear, enable and expired outputs, sized to clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. Model slave returns 0 at addr 0 and 1643044096 at addr 1, waitrequest=0, AUTO_START=1 -> done=1 at cycle 4 after reset release, pass=1, err=00, id_q=0, ts_q=1643044096.
2. Model slave returns 32'h0000_0005 at addr 0 -> done=1, pass=0, err=01, id_q=5; timestamp still read and captured.
3. Addr 1 returns 1643044097 -> err=10, pass=0.
4. waitrequest held high for 3 cycles on each read -> avm_address/avm_read stable during stall, done at cycle 10, pass=1.
5. waitrequest stuck high with TIMEOUT_CYCLES=8 -> avm_read drops after 8 stall cycles, err=11, done=1, busy=0. Repeat with a 7-cycle stall then accept -> pass=1.
6. Assert reset_n during RD_TS, release, then pulse start with AUTO_START=0 -> outputs at reset values until the check completes; extra start pulses while busy cause no additional reads (count exactly 2 accepted reads).
